// File: rtl/iob_fp_reduce_seq.sv
// Sequencer reducing a stream of LEN floating-point words to one sum through an external pipelined adder.
// Optional macro IOB_FP_REDUCE_ZERO_SKIP_EN: accepted +/-0 elements are consumed without entering hold or the adder.
module iob_fp_reduce_seq #(
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              add_start_o,
    output logic [DATA_W-1:0] add_op_a_o,
    output logic [DATA_W-1:0] add_op_b_o,
    input  logic              add_done_i,
    input  logic [DATA_W-1:0] add_res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] sum_o
);
    localparam int IFW = $clog2(ADD_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_rem_in;
    logic [IFW-1:0]    r_in_flight;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_v;
    logic              r_add_start;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_sum;

    logic w_run;
    logic w_in_zero;
    logic w_acc;
    logic w_src_r;
    logic w_src_i;
    logic w_issue;

    assign w_run = (r_state == RUN);

`ifdef IOB_FP_REDUCE_ZERO_SKIP_EN
    assign w_in_zero = (in_data_i[DATA_W-2:0] == '0);
`else
    assign w_in_zero = 1'b0;
`endif

    // A returning result and a held value already make a pair, so a new element must wait.
    assign in_ready_o = w_run && (r_rem_in != '0) && !(add_done_i && r_hold_v && !w_in_zero);
    assign w_acc      = in_valid_i && in_ready_o;
    assign w_src_r    = w_run && add_done_i;
    assign w_src_i    = w_acc && !w_in_zero;
    assign w_issue    = (w_src_r && (r_hold_v || w_src_i)) || (r_hold_v && w_src_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_rem_in    <= '0;
            r_in_flight <= '0;
            r_hold      <= '0;
            r_hold_v    <= 1'b0;
            r_add_start <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
        end else begin
            r_add_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state     <= RUN;
                        r_rem_in    <= len_i;
                        r_in_flight <= '0;
                        r_hold_v    <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_acc)
                        r_rem_in <= r_rem_in - CNT_W'(1);
                    if (w_issue && !w_src_r)
                        r_in_flight <= r_in_flight + IFW'(1);
                    else if (!w_issue && w_src_r)
                        r_in_flight <= r_in_flight - IFW'(1);

                    // Priority R > H > I; any two sources form one addition.
                    if (w_src_r && r_hold_v) begin
                        r_add_start <= 1'b1;
                        r_op_a      <= add_res_i;
                        r_op_b      <= r_hold;
                        r_hold_v    <= 1'b0;
                    end else if (w_src_r && w_src_i) begin
                        r_add_start <= 1'b1;
                        r_op_a      <= add_res_i;
                        r_op_b      <= in_data_i;
                    end else if (r_hold_v && w_src_i) begin
                        r_add_start <= 1'b1;
                        r_op_a      <= r_hold;
                        r_op_b      <= in_data_i;
                        r_hold_v    <= 1'b0;
                    end else if (w_src_r) begin
                        r_hold   <= add_res_i;
                        r_hold_v <= 1'b1;
                    end else if (w_src_i) begin
                        r_hold   <= in_data_i;
                        r_hold_v <= 1'b1;
                    end

                    if (r_rem_in == '0 && r_in_flight == '0 && !add_done_i) begin
                        r_state <= FIN;
                        r_sum   <= r_hold_v ? r_hold : '0;
                    end
                end
                FIN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign add_start_o = r_add_start;
    assign add_op_a_o  = r_op_a;
    assign add_op_b_o  = r_op_b;
    assign busy_o      = w_run;
    assign done_o      = (r_state == FIN);
    assign sum_o       = r_sum;
endmodule

// File: tb/tb_iob_fp_reduce_seq.sv
// Scoreboard bench for iob_fp_reduce_seq with a behavioural 5-cycle FP adder standing in for iob_fp_add.
module tb_iob_fp_reduce_seq;
    localparam int DATA_W  = 32;
    localparam int ADD_LAT = 5;
    localparam int CNT_W   = 16;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              start_i = 1'b0;
    logic [CNT_W-1:0]  len_i = '0;
    logic              in_valid_i = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              in_ready_o;
    logic              add_start_o;
    logic [DATA_W-1:0] add_op_a_o;
    logic [DATA_W-1:0] add_op_b_o;
    logic              add_done_i;
    logic [DATA_W-1:0] add_res_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] sum_o;

    iob_fp_reduce_seq #(.DATA_W(DATA_W), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .add_start_o(add_start_o), .add_op_a_o(add_op_a_o), .add_op_b_o(add_op_b_o),
        .add_done_i(add_done_i), .add_res_i(add_res_i),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  a;
        int   e;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    function automatic bit is_skip(input logic [31:0] d);
`ifdef IOB_FP_REDUCE_ZERO_SKIP_EN
        return d[30:0] == 31'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural pipelined adder, ADD_LAT cycles from add_start_o to add_done_i.
    logic        pv [ADD_LAT];
    logic [31:0] pd [ADD_LAT];
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ADD_LAT; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else begin
            pv[0] <= add_start_o;
            pd[0] <= r2f(f2r(add_op_a_o) + f2r(add_op_b_o));
            for (int i = 1; i < ADD_LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
        end
    end
    assign add_done_i = pv[ADD_LAT-1];
    assign add_res_i  = pd[ADD_LAT-1];

    typedef struct {
        logic [31:0] sum;
        int          iss;
        int          len;
    } exp_t;
    exp_t exp_q[$];

    // Monitor / scoreboard
    int          cyc_cnt = 0;
    int          done_cnt = 0;
    int          mon_len = 0, mon_acc = 0, mon_iss = 0, rdy_bad = 0, start_cyc = 0;
    bit          post_done = 0, pair_pend = 0, pb_v = 0;
    logic [31:0] pa = '0, pb = '0;

    always @(negedge clk_i) begin
        exp_t e;
        bit   acc;
        if (!rst_n_i) begin
            pair_pend = 0;
            post_done = 0;
        end else begin
            cyc_cnt++;
            if (post_done) begin
                chk("busy_after_done", {31'd0, busy_o}, 32'd0);
                chk("done_one_cycle", {31'd0, done_o}, 32'd0);
                post_done = 0;
            end
            if (pair_pend) begin
                chk("pair_start", {31'd0, add_start_o}, 32'd1);
                chk("pair_op_a", add_op_a_o, pa);
                if (pb_v) chk("pair_op_b", add_op_b_o, pb);
                pair_pend = 0;
            end
            if (start_i && !busy_o && !done_o) begin
                mon_len = int'(len_i); mon_acc = 0; mon_iss = 0; rdy_bad = 0; start_cyc = cyc_cnt;
            end
            if (add_start_o) mon_iss++;
            if (in_ready_o && mon_acc >= mon_len) rdy_bad++;
            acc = in_valid_i && in_ready_o;
            if (add_done_i && busy_o) begin
                if (acc && !is_skip(in_data_i)) begin
                    pair_pend = 1; pa = add_res_i; pb = in_data_i; pb_v = 1;
                end else if (!in_ready_o && mon_acc < mon_len) begin
                    pair_pend = 1; pa = add_res_i; pb_v = 0;
                end
            end
            if (acc) mon_acc++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", sum_o, e.sum);
                    chk("issue_count", mon_iss, e.iss);
                    chk("accept_count", mon_acc, e.len);
                    chk("ready_with_no_remaining", rdy_bad, 0);
                    if (e.len == 0) chk("len0_done_latency", cyc_cnt - start_cyc, 2);
                end
                post_done = 1;
                done_cnt++;
            end
        end
    end

    // Stimulus
    logic [31:0] stim[$];

    task automatic pulse_start(input int len);
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = CNT_W'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic drive(input int mode, input bit mid_start, input int stop_at);
        int idx = 0, cyc = 0;
        bit take;
        while (idx < stop_at && cyc < 4000) begin
            case (mode)
                0: in_valid_i = 1'b1;
                1: in_valid_i = (cyc % 2 == 0);
                default: in_valid_i = ($urandom_range(0, 2) != 0);
            endcase
            in_data_i = stim[idx];
            start_i = mid_start && (cyc == 3);
            if (start_i) len_i = CNT_W'(5);
            @(negedge clk_i);
            take = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            cyc++;
            if (take) idx++;
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        if (idx < stop_at) begin
            checks++; errors++;
            $display("FAIL input_timeout accepted=%0d required=%0d", idx, stop_at);
        end
    endtask

    task automatic run(input int mode, input bit mid_start);
        exp_t e;
        real  tot = 0.0;
        int   nz = 0, n = 0, d0;
        foreach (stim[i]) begin
            tot += f2r(stim[i]);
            if (stim[i][30:0] != 31'd0) nz++;
        end
        e.sum = r2f(tot);
        e.len = stim.size();
`ifdef IOB_FP_REDUCE_ZERO_SKIP_EN
        e.iss = (nz > 0) ? nz - 1 : 0;
`else
        e.iss = (e.len > 0) ? e.len - 1 : 0;
`endif
        exp_q.push_back(e);
        d0 = done_cnt;
        pulse_start(e.len);
        drive(mode, mid_start, e.len);
        while (done_cnt == d0 && n < 500) begin @(posedge clk_i); n++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=none required=done_o");
            void'(exp_q.pop_front());
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_add_start", {31'd0, add_start_o}, 32'd0);
        chk("rst_op_a", add_op_a_o, 32'd0);
        chk("rst_op_b", add_op_b_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_sum", sum_o, 32'd0);
        @(posedge clk_i); #3;
        rst_n_i = 1'b1;

        stim = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run(0, 0);
        chk("sum_len4_value", sum_o, 32'h41200000);

        stim = '{32'h40490FDB};
        run(0, 0);
        stim.delete();
        run(0, 0);

        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(32'h3F800000);
        run(1, 1);
        chk("sum_len16_value", sum_o, 32'h41800000);

        // Abandon a LEN=8 reduction after three elements.
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(32'h3F800000);
        pulse_start(8);
        drive(0, 0, 3);
        @(negedge clk_i); #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("midrst_add_start", {31'd0, add_start_o}, 32'd0);
        chk("midrst_op_a", add_op_a_o, 32'd0);
        chk("midrst_op_b", add_op_b_o, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        chk("midrst_sum", sum_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        stim = '{32'h3F800000, 32'h3F800000};
        run(0, 0);
        chk("sum_after_reset", sum_o, 32'h40000000);

        stim = '{32'h00000000, 32'h80000000, 32'h3F800000};
        run(0, 0);
        stim = '{32'h00000000, 32'h00000000};
        run(2, 0);

        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(0, 20);
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back(r2f(real'($urandom_range(0, 15))));
            run($urandom_range(0, 2), 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
